// File: rtl/round_robin_arb4_pkg.sv
// ============================================================================
// arb_pkg : shared types, sizes and helpers for the 4-way round-robin arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package arb_pkg;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned ID_W    = 2;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   // First requester at or after (last+1) mod NUM_REQ; last itself is checked last.
   function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [ID_W-1:0]    last);
      logic [ID_W-1:0] idx;
      rr_pick = last;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = last + ID_W'(k);
         if (req[idx]) rr_pick = idx;
      end
   endfunction

   function automatic logic [ID_W-1:0] onehot_enc(input logic [NUM_REQ-1:0] vec);
      onehot_enc = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (vec[i]) onehot_enc = ID_W'(i);
      end
   endfunction

endpackage

`default_nettype wire

// File: rtl/round_robin_arb4_if.sv
// ============================================================================
// round_robin_arb4_if : request/grant bundle between requesters and arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

interface round_robin_arb4_if;
   import arb_pkg::*;

   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] rel;
   logic [NUM_REQ-1:0] gnt;
   logic [ID_W-1:0]    gnt_id;
   logic               busy;
   logic               timeout;
   logic               err;

   modport master (
      output req, rel,
      input  gnt, gnt_id, busy, timeout, err
   );

   modport slave (
      input  req, rel,
      output gnt, gnt_id, busy, timeout, err
   );

endinterface

`default_nettype wire

// File: rtl/round_robin_arb4_onehot0_check.sv
// ============================================================================
// onehot0_check : combinational zero-or-one-hot test of a 4-bit vector
// Revision: 1.0
// ============================================================================
`default_nettype none

module onehot0_check
   import arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] vec_i,
   output logic               ok_o
);

   assign ok_o = ((vec_i & (vec_i - NUM_REQ'(1))) == '0);

endmodule

`default_nettype wire

// File: rtl/round_robin_arb4.sv
// ============================================================================
// round_robin_arb4 : 4-way round-robin arbiter with hold timeout and grant check
// Revision: 1.0
// ============================================================================
`default_nettype none

module round_robin_arb4
   import arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 15,
   parameter int unsigned CNT_W    = 8
) (
   input  logic                clk,
   input  logic                rst,
   round_robin_arb4_if.slave   bus
);

   localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(MAX_HOLD - 1);
   localparam logic [CNT_W-1:0] C_MAX_CNT  = {CNT_W{1'b1}};

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [ID_W-1:0]    last_id_q, last_id_d;
   logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic               timeout_q, timeout_d;
   logic               err_q, err_d;
   logic [ID_W-1:0]    pick_id;
   logic               owner_done;
   logic               gnt_ok;

   // The check observes the grant as seen on the bus, not the internal register.
   onehot0_check u_onehot0_check (
      .vec_i (bus.gnt),
      .ok_o  (gnt_ok)
   );

   assign pick_id    = rr_pick(bus.req, last_id_q);
   assign owner_done = bus.rel[last_id_q] | ~bus.req[last_id_q];

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      last_id_d  = last_id_q;
      hold_cnt_d = hold_cnt_q;
      timeout_d  = 1'b0;
      err_d      = err_q | ~gnt_ok;
      case (state_q)
         ST_IDLE: begin
            if (|bus.req) begin
               state_d    = ST_HOLD;
               gnt_d      = NUM_REQ'(1) << pick_id;
               last_id_d  = pick_id;
               hold_cnt_d = '0;
            end
         end
         ST_HOLD: begin
            // Normal release takes precedence over a coincident timeout.
            if (owner_done) begin
               state_d = ST_IDLE;
               gnt_d   = '0;
            end else if (hold_cnt_q == C_LAST_CNT) begin
               state_d   = ST_IDLE;
               gnt_d     = '0;
               timeout_d = 1'b1;
            end else if (hold_cnt_q != C_MAX_CNT) begin
               hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         gnt_q      <= '0;
         last_id_q  <= ID_W'(NUM_REQ - 1);
         hold_cnt_q <= '0;
         timeout_q  <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         last_id_q  <= last_id_d;
         hold_cnt_q <= hold_cnt_d;
         timeout_q  <= timeout_d;
         err_q      <= err_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.gnt_id  = onehot_enc(gnt_q);
   assign bus.busy    = |gnt_q;
   assign bus.timeout = timeout_q;
   assign bus.err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_round_robin_arb4.sv
// ============================================================================
// tb_round_robin_arb4 : directed vector table plus timeout/release/err sequences
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_round_robin_arb4;
   import arb_pkg::*;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] rel;
      logic [3:0] gnt;
      logic [1:0] gnt_id;
      logic       busy;
      logic       timeout;
   } vec_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   vec_t vq[$];

   round_robin_arb4_if arb_bus ();

   round_robin_arb4 #(
      .MAX_HOLD (15),
      .CNT_W    (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (arb_bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] rl,
                      input logic [3:0] g, input logic [1:0] id, input logic b,
                      input logic t);
      vec_t v;
      v.rst = r; v.req = rq; v.rel = rl;
      v.gnt = g; v.gnt_id = id; v.busy = b; v.timeout = t;
      vq.push_back(v);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      arb_bus.req = '0;
      arb_bus.rel = '0;

      //   rst  req      rel      gnt      id     busy  to
      add(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0);  // reset state
      add(0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1, 0);  // single grant, latency 1
      add(0, 4'b0001, 4'b0001, 4'b0000, 2'd0, 0, 0);  // release
      add(1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 0, 0);  // rotation: restart from reset
      add(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1, 0);
      add(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1, 0);
      add(0, 4'b1111, 4'b0001, 4'b0000, 2'd0, 0, 0);
      add(0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1, 0);
      add(0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1, 0);
      add(0, 4'b1111, 4'b0010, 4'b0000, 2'd0, 0, 0);
      add(0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 1, 0);
      add(0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 1, 0);
      add(0, 4'b1111, 4'b0100, 4'b0000, 2'd0, 0, 0);
      add(0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1, 0);
      add(0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1, 0);
      add(0, 4'b1111, 4'b1000, 4'b0000, 2'd0, 0, 0);
      add(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1, 0);  // wraps back to 0
      add(0, 4'b1111, 4'b0001, 4'b0000, 2'd0, 0, 0);
      add(0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1, 0);  // owner 1
      add(0, 4'b0010, 4'b1101, 4'b0010, 2'd1, 1, 0);  // non-owner rel ignored
      add(0, 4'b1111, 4'b1101, 4'b0010, 2'd1, 1, 0);  // non-owner req ignored
      add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0);  // owner drops req
      add(0, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1, 0);
      add(1, 4'b1000, 4'b0000, 4'b0000, 2'd0, 0, 0);  // reset mid-hold
      add(0, 4'b1001, 4'b0000, 4'b0001, 2'd0, 1, 0);  // 0 has top priority
      add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0);

      foreach (vq[i]) begin
         rst         = vq[i].rst;
         arb_bus.req = vq[i].req;
         arb_bus.rel = vq[i].rel;
         tick();
         chk($sformatf("v%0d gnt", i),     32'(arb_bus.gnt),     32'(vq[i].gnt));
         chk($sformatf("v%0d gnt_id", i),  32'(arb_bus.gnt_id),  32'(vq[i].gnt_id));
         chk($sformatf("v%0d busy", i),    32'(arb_bus.busy),    32'(vq[i].busy));
         chk($sformatf("v%0d timeout", i), 32'(arb_bus.timeout), 32'(vq[i].timeout));
         chk($sformatf("v%0d err", i),     32'(arb_bus.err),     32'(0));
      end

      // Timeout: requester 2 never releases.
      rst = 1'b1; arb_bus.req = '0; arb_bus.rel = '0;
      tick();
      rst = 1'b0; arb_bus.req = 4'b0100;
      for (int c = 0; c < 15; c++) begin
         tick();
         chk($sformatf("to hold c%0d gnt", c), 32'(arb_bus.gnt), 32'(4'b0100));
         chk($sformatf("to hold c%0d pulse", c), 32'(arb_bus.timeout), 32'(0));
      end
      tick();
      chk("to revoke gnt", 32'(arb_bus.gnt), 32'(0));
      chk("to revoke pulse", 32'(arb_bus.timeout), 32'(1));
      tick();
      chk("to regrant gnt", 32'(arb_bus.gnt), 32'(4'b0100));
      chk("to regrant pulse", 32'(arb_bus.timeout), 32'(0));
      chk("to err", 32'(arb_bus.err), 32'(0));

      // Release coinciding with the last allowed hold cycle.
      rst = 1'b1; arb_bus.req = '0;
      tick();
      rst = 1'b0; arb_bus.req = 4'b0010;
      for (int c = 0; c < 15; c++) tick();
      chk("rel-last gnt before", 32'(arb_bus.gnt), 32'(4'b0010));
      arb_bus.rel = 4'b0010;
      tick();
      chk("rel-last gnt", 32'(arb_bus.gnt), 32'(0));
      chk("rel-last pulse", 32'(arb_bus.timeout), 32'(0));
      arb_bus.rel = '0; arb_bus.req = '0;
      tick();
      chk("rel-last idle pulse", 32'(arb_bus.timeout), 32'(0));

      // Illegal grant on the bus sets the sticky error flag.
      force arb_bus.gnt = 4'b0011;
      tick();
      chk("err set", 32'(arb_bus.err), 32'(1));
      release arb_bus.gnt;
      tick();
      chk("err gnt restored", 32'(arb_bus.gnt), 32'(0));
      chk("err sticky", 32'(arb_bus.err), 32'(1));
      rst = 1'b1;
      tick();
      chk("err cleared", 32'(arb_bus.err), 32'(0));
      rst = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
